// File: rtl/online_adder_rn_if.sv
// Streaming port bundle for the online signed-digit adder: input pair side,
// result digit side and the sticky error flag.
interface online_adder_rn_if #(
  parameter int unsigned R_LOG2 = 2
);
  localparam int unsigned DW = R_LOG2 + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic                 sub;
  logic signed [DW-1:0] xi;
  logic signed [DW-1:0] yi;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] zi;
  logic                 out_first;
  logic                 out_last;
  logic                 err;

  // Producer/consumer side that drives digit pairs and takes results.
  modport master (
    output in_valid, in_last, sub, xi, yi, out_ready,
    input  in_ready, out_valid, zi, out_first, out_last, err
  );

  // The adder itself.
  modport slave (
    input  in_valid, in_last, sub, xi, yi, out_ready,
    output in_ready, out_valid, zi, out_first, out_last, err
  );
endinterface

// File: rtl/online_adder_rn.sv
// Radix-2^R_LOG2 MSD-first signed-digit adder/subtractor, online delay 1.
// Each accepted pair j emits z_{j-1} = w_{j-1} + t_j; one flush beat emits w_M.
module online_adder_rn #(
  parameter int unsigned R_LOG2 = 2,
  parameter int unsigned A      = 3,
  parameter int unsigned N      = 8
) (
  input logic              clk,
  input logic              reset_n,
  online_adder_rn_if.slave bus
);
  localparam int unsigned DW = R_LOG2 + 1;
  localparam int unsigned SW = DW + 1;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic signed [SW-1:0] AP = SW'(A);

  if (!((A > (2 ** R_LOG2) / 2) && (A <= (2 ** R_LOG2) - 1))) begin : gen_bad_a
    $error("online_adder_rn: A must satisfy r/2 < A <= r-1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sub_q, sub_d;
  logic signed [DW-1:0] w_q, w_d;
  logic signed [DW-1:0] z_q, z_d;
  logic                 ov_q, ov_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;

  logic                 slot_free, in_ready, accept;
  logic                 sub_eff, t_pos, t_neg, bad, last_pair;
  logic signed [SW-1:0] x_ext, y_ext, y_sel, s;
  logic signed [DW-1:0] w_new, t_dig;
  logic [CW-1:0]        cnt_next;

  assign slot_free = !ov_q || bus.out_ready;

  // Per-pair digit arithmetic: sum, transfer digit and interim sum.
  always_comb begin
    sub_eff  = (state_q == StIdle) ? bus.sub : sub_q;
    x_ext    = {bus.xi[DW-1], bus.xi};
    y_ext    = {bus.yi[DW-1], bus.yi};
    y_sel    = sub_eff ? -y_ext : y_ext;
    s        = x_ext + y_sel;
    t_pos    = (s >= AP);
    t_neg    = (s <= -AP);
    // Subtracting/adding r only flips the top bit once truncated to DW bits.
    w_new    = {s[DW-1] ^ (t_pos | t_neg), s[DW-2:0]};
    t_dig    = t_pos ? DW'(1) : (t_neg ? {DW{1'b1}} : '0);
    bad      = (x_ext > AP) || (x_ext < -AP) || (y_ext > AP) || (y_ext < -AP);
    cnt_next = (state_q == StIdle) ? CW'(1) : cnt_q + 1'b1;
    last_pair = bus.in_last || (cnt_next == CW'(N));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next-state: a frame closes on in_last or its N-th pair, then flushes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRun: if (accept) state_d = last_pair ? StFlush : StRun;
      StFlush:       if (slot_free) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  // FSM outputs: in_ready never depends on in_valid.
  always_comb begin
    in_ready = reset_n && slot_free && (state_q != StFlush);
    accept   = bus.in_valid && in_ready;
  end

  // Datapath next-state: load a result on accept or flush, else drain.
  always_comb begin
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    w_d     = w_q;
    z_d     = z_q;
    ov_d    = ov_q;
    first_d = first_q;
    last_d  = last_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = cnt_next;
      sub_d   = sub_eff;
      w_d     = w_new;
      z_d     = w_q + t_dig;
      ov_d    = 1'b1;
      first_d = (state_q == StIdle);
      last_d  = 1'b0;
      err_d   = ((state_q == StIdle) ? 1'b0 : err_q) | bad;
    end else if ((state_q == StFlush) && slot_free) begin
      cnt_d   = '0;
      w_d     = '0;
      z_d     = w_q;
      ov_d    = 1'b1;
      first_d = 1'b0;
      last_d  = 1'b1;
    end else if (bus.out_ready) begin
      ov_d    = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      w_q     <= '0;
      z_q     <= '0;
      ov_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      w_q     <= w_d;
      z_q     <= z_d;
      ov_q    <= ov_d;
      first_q <= first_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ov_q;
  assign bus.zi        = z_q;
  assign bus.out_first = first_q;
  assign bus.out_last  = last_q;
  assign bus.err       = err_q;
endmodule

// File: doc/online_adder_rn.md
# online_adder_rn

Parametrised radix-2^R_LOG2 online (MSD-first) signed-digit adder/subtractor with valid/ready streaming on both sides and frame control. Each cycle it accepts one digit pair x_j, y_j and emits one result digit, with online delay 1. After the last input digit it emits one extra flush digit. It replaces the fixed radix-4, enable-gated adder in the online-arithmetic datapath and the UART test harness. It also fixes carry alignment: the transfer digit of position j+1 is added to the interim sum of position j.

## Interface
- R_LOG2, 2: radix r = 2^R_LOG2.
- A, 3: digit-set bound, digits in [-A, A]. Legal range r/2 < A ≤ r-1. Elaboration fails otherwise.
- N, 8: maximum input digits per frame.
- DW, R_LOG2+1: digit width, two's complement (derived, not overridden).
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input digit pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- in_last  in  1  marks the final pair of the frame.
- sub  in  1  1 = compute x − y. Sampled with the first pair of a frame and held for the whole frame.
- xi  in  DW  signed input digit x_j.
- yi  in  DW  signed input digit y_j.
- out_valid  out  1  zi holds a valid result digit.
- out_ready  in  1  downstream consumes zi.
- zi  out  DW  signed result digit z_{j-1}.
- out_first  out  1  zi is z_0.
- out_last  out  1  zi is z_N, the frame's final digit.
- err  out  1  sticky: a digit outside [-A, A] was accepted in the current frame.

## Operation
- **Accept.** A pair is accepted on a clk edge when in_valid && in_ready.
- **Per accepted pair j (1-based):**
  - y' = sub_frame ? −y_j : y_j.
  - s = x_j + y', computed at DW+1 bits.
  - s ≥ A → t = 1, w = s − r.
  - s ≤ −A → t = −1, w = s + r.
  - otherwise t = 0, w = s.
- **Output per pair.** Emit z_{j-1} = w_prev + t, where w_prev is the registered w of pair j−1 (0 for j = 1). The result always lies in [-A, A], so no saturation is needed.
- **States:**
  - IDLE: no frame open, in_ready = out-slot free.
  - RUN: frame open, in_ready = out-slot free.
  - FLUSH: in_ready = 0.
- **Out-slot free** means !out_valid || out_ready.
- **Transitions:**
  - IDLE→RUN on the first accept. On that accept: latch sub_frame, clear err, load counter = 1, set out_first on z_0.
  - RUN stays in RUN on each accept, counter increments.
  - RUN→FLUSH on accepting a pair with in_last = 1, or the N-th pair. A frame therefore never exceeds N pairs; in_last on pair N is redundant.
  - FLUSH→IDLE when the out-slot is free. At that point load zi = w_prev, out_last = 1, and w_prev = 0.
  - A single-pair frame emits z_0 and then z_1 (out_first and out_last on different beats).
- **Output register.** zi, out_first and out_last are registered. Flags are valid only while out_valid = 1.
  - If out_valid && !out_ready, all output state holds.
  - out_valid drops after a consume when nothing new is loaded.
- **err.** Set when an accepted xi or yi has |value| > A. The pair is still processed, but the result is undefined for that frame. err clears on the next frame's first accept.
- **Reset.** Asynchronous reset_n = 0, including mid-frame, forces:
  - state IDLE, w_prev 0, counter 0, sub_frame 0;
  - zi 0, out_valid 0, out_first 0, out_last 0, err 0.
  - in_ready is 0 while reset_n = 0 and becomes 1 on the first cycle after release.
  - Any partial frame is discarded.

## Timing
- Latency: a pair accepted at edge k produces its result digit with out_valid = 1 immediately after edge k.
- Each frame of M input pairs yields exactly M+1 output beats.
- Throughput is 1 pair/cycle while out_ready = 1. The FLUSH beat costs one input-idle cycle per frame.
- Simultaneous consume and accept on one edge is legal; the new digit replaces the old one.
- in_ready depends combinationally on out_ready and state, with no combinational path from in_valid.

## Test plan
- **Carry chain** (R_LOG2=2, A=3, sub=0): x=[1,2,−1,3], y=[2,2,0,1] with in_last on pair 4 → zi=[1,0,0,0,0]. out_first is set on beat 1 and out_last on beat 5.
- **Max/min bounds:**
  - x=y=[3,3,3,3] → [1,3,3,3,2].
  - x=y=[−3,−3,−3,−3] → [−1,−3,−3,−3,−2].
- **Subtract:** sub=1 on pair 1, then deasserted mid-frame; x=y=[1,2,−1,3] → five beats of 0, since sub stays latched for the frame.
- **Backpressure:** hold out_ready=0 for 3 cycles after beat 2 → in_ready=0, zi and flags stable. Resume → identical digit sequence with no drops or duplicates.
- **Framing:**
  - N=4 with in_last never asserted → FLUSH after pair 4, 5 output beats.
  - Single pair x=[2], y=[2] with in_last → beats [1, 0].
  - Back-to-back frames produce no cross-frame w_prev leakage.
- **Errors/reset:**
  - xi=−4 accepted → err=1; err clears on the next frame's first accept.
  - reset_n pulsed low asynchronously mid-frame → all outputs 0 at once, then a clean new frame after release.
